// File: rtl/testbench_ls_ram_pkg.sv
// Shared widths and FSM state type for the system-RAM arbiter slice.
package testbench_ls_ram_pkg;
   localparam int unsigned RAM_AW  = 17;
   localparam int unsigned RAM_DW  = 32;
   localparam int unsigned RAM_BEW = 4;
   localparam int unsigned STAT_W  = 16;

   typedef enum logic {
      IDLE,
      OWNED
   } arb_state_t;
endpackage

// File: rtl/testbench_ls_ram_arbiter_if.sv
// Requester-side Avalon-MM bundle plus RAM-side port of the arbiter.
interface testbench_ls_ram_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);
   import testbench_ls_ram_pkg::*;

   logic [NUM_REQ*RAM_AW-1:0]  m_address;
   logic [NUM_REQ*RAM_BEW-1:0] m_byteenable;
   logic [NUM_REQ-1:0]         m_read;
   logic [NUM_REQ-1:0]         m_write;
   logic [NUM_REQ*RAM_DW-1:0]  m_writedata;
   logic [NUM_REQ-1:0]         m_waitrequest;
   logic [RAM_DW-1:0]          m_readdata;
   logic [NUM_REQ-1:0]         m_readdatavalid;

   logic [RAM_AW-1:0]          ram_address;
   logic [RAM_BEW-1:0]         ram_byteenable;
   logic [RAM_DW-1:0]          ram_writedata;
   logic                       ram_chipselect;
   logic                       ram_write;
   logic                       ram_clken;
   logic [RAM_DW-1:0]          ram_readdata;

   modport master (
      output m_address, m_byteenable, m_read, m_write, m_writedata, ram_readdata,
      input  m_waitrequest, m_readdata, m_readdatavalid,
      input  ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write, ram_clken
   );

   modport slave (
      input  m_address, m_byteenable, m_read, m_write, m_writedata, ram_readdata,
      output m_waitrequest, m_readdata, m_readdatavalid,
      output ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write, ram_clken
   );
endinterface

// File: rtl/testbench_ls_rr_pick.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping modulo NUM_REQ.
module testbench_ls_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IW      = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic [IW-1:0]      winner,
   output logic               any
);
   logic          found;
   logic [IW-1:0] sel;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      sel    = '0;
      any    = |req;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sel = IW'((32'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[sel]) begin
            winner = sel;
            found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/testbench_ls_ram_arbiter.sv
// Round-robin arbiter sharing one system RAM among NUM_REQ Avalon-MM requesters.
// Define TESTBENCH_LS_RAM_ARB_STATS_EN to add per-requester grant/stall counters.
module testbench_ls_ram_arbiter
   import testbench_ls_ram_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   testbench_ls_ram_arbiter_if.slave bus
`ifdef TESTBENCH_LS_RAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0] stat_grants,
   output logic [NUM_REQ*STAT_W-1:0] stat_stalls
`endif
);
   localparam int unsigned IW       = (NUM_REQ > 2) ? 2 : 1;
   localparam logic [3:0]  HOLD_LIM = 4'(MAX_HOLD);

   arb_state_t         state, state_nxt;
   logic [IW-1:0]      owner, owner_nxt;
   logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
   logic [IW-1:0]      pick;
   logic [IW-1:0]      rdv_owner;
   logic [3:0]         hold_cnt, hold_nxt;
   logic               rdv_pend;
   logic [NUM_REQ-1:0] req, owner_mask, waitreq, rdvalid;
   logic               any_req, owner_req, others_req, accept, acc_read;

   testbench_ls_rr_pick #(
      .NUM_REQ(NUM_REQ),
      .IW     (IW)
   ) u_pick (
      .req   (req),
      .rr_ptr(rr_ptr),
      .winner(pick),
      .any   (any_req)
   );

   assign req = bus.m_read | bus.m_write;

   always_comb begin
      owner_mask        = '0;
      owner_mask[owner] = 1'b1;
   end

   assign owner_req  = req[owner];
   assign others_req = |(req & ~owner_mask);
   assign accept     = (state == OWNED) && owner_req;
   // A simultaneous read+write is treated as a write only, so no read data returns.
   assign acc_read   = accept && bus.m_read[owner] && !bus.m_write[owner];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         rdv_pend  <= 1'b0;
         rdv_owner <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rr_ptr    <= rr_ptr_nxt;
         hold_cnt  <= hold_nxt;
         rdv_pend  <= acc_read;
         rdv_owner <= owner;
      end
   end

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      hold_nxt   = hold_cnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               owner_nxt = pick;
               hold_nxt  = '0;
               state_nxt = OWNED;
            end
         end
         OWNED: begin
            if (!owner_req) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
            end else begin
               // Saturates at MAX_HOLD so a late competitor still forces a hand-off.
               hold_nxt = (hold_cnt >= HOLD_LIM) ? HOLD_LIM : hold_cnt + 4'd1;
               if (hold_nxt == HOLD_LIM && others_req) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      waitreq = '1;
      if (state == OWNED) waitreq[owner] = 1'b0;
      rdvalid = '0;
      if (rdv_pend) rdvalid[rdv_owner] = 1'b1;
   end

   assign bus.m_waitrequest   = waitreq;
   assign bus.m_readdatavalid = rdvalid;
   assign bus.m_readdata      = bus.ram_readdata;
   assign bus.ram_chipselect  = accept;
   assign bus.ram_write       = accept && bus.m_write[owner];
   assign bus.ram_address     = bus.m_address[32'(owner)*RAM_AW +: RAM_AW];
   assign bus.ram_byteenable  = bus.m_byteenable[32'(owner)*RAM_BEW +: RAM_BEW];
   assign bus.ram_writedata   = bus.m_writedata[32'(owner)*RAM_DW +: RAM_DW];
   assign bus.ram_clken       = !reset;

`ifdef TESTBENCH_LS_RAM_ARB_STATS_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      logic [STAT_W-1:0] grant_cnt, stall_cnt;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
         end else begin
            if (accept && owner == IW'(i) && grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
            if (req[i] && waitreq[i] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         end
      end

      assign stat_grants[i*STAT_W +: STAT_W] = grant_cnt;
      assign stat_stalls[i*STAT_W +: STAT_W] = stall_cnt;
   end
`endif
endmodule

// File: tb/tb_testbench_ls_ram_arbiter.sv
// Directed bench for testbench_ls_ram_arbiter with a 1-cycle-latency RAM model.
// Define TESTBENCH_LS_RAM_ARB_STATS_EN to also check the statistics counters.
module tb_testbench_ls_ram_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_miss = 0;

   testbench_ls_ram_arbiter_if #(.NUM_REQ(2)) bus ();

`ifdef TESTBENCH_LS_RAM_ARB_STATS_EN
   logic [31:0] stat_grants, stat_stalls;
`endif

   testbench_ls_ram_arbiter #(
      .NUM_REQ (2),
      .MAX_HOLD(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef TESTBENCH_LS_RAM_ARB_STATS_EN
      ,
      .stat_grants(stat_grants),
      .stat_stalls(stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (bus.ram_chipselect && bus.ram_clken) begin
         if (bus.ram_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_byteenable[b])
                  mem[bus.ram_address[7:0]][b*8 +: 8] <= bus.ram_writedata[b*8 +: 8];
         end else begin
            bus.ram_readdata <= mem[bus.ram_address[7:0]];
         end
      end
   end

   // Expected waitrequest per cycle of the dual streaming test (rr_ptr starts at 1).
   logic [1:0] exp_wr [15] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01,
                               2'b11, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b11, 2'b01, 2'b01, 2'b01, 2'b01};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input int r, input string tag);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (!bus.m_waitrequest[r]) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check_val({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic set_fields(input int r, input logic [16:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
      bus.m_address[r*17 +: 17]  = addr;
      bus.m_writedata[r*32 +: 32] = data;
      bus.m_byteenable[r*4 +: 4]  = be;
   endtask

   task automatic do_write(input int r, input logic [16:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
      set_fields(r, addr, data, be);
      bus.m_write[r] = 1'b1;
      wait_grant(r, "wr_grant");
      check_val("wr_cs", 32'(bus.ram_chipselect), 32'd1);
      check_val("wr_we", 32'(bus.ram_write), 32'd1);
      check_val("wr_addr", 32'(bus.ram_address), 32'(addr));
      check_val("wr_data", bus.ram_writedata, data);
      @(negedge clk);
      bus.m_write[r] = 1'b0;
   endtask

   task automatic do_read(input int r, input logic [16:0] addr, input logic [31:0] exp);
      set_fields(r, addr, 32'd0, 4'hF);
      bus.m_read[r] = 1'b1;
      wait_grant(r, "rd_grant");
      check_val("rd_cs", 32'(bus.ram_chipselect), 32'd1);
      check_val("rd_we", 32'(bus.ram_write), 32'd0);
      @(negedge clk);
      bus.m_read[r] = 1'b0;
      #1;
      check_val("rd_valid", 32'(bus.m_readdatavalid), 32'd1 << r);
      check_val("rd_data", bus.m_readdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [1:0] exp_rdv;
      int cnt;
      bus.m_address = '0;
      bus.m_byteenable = '0;
      bus.m_read = '0;
      bus.m_write = '0;
      bus.m_writedata = '0;
      bus.ram_readdata = '0;

      // Reset state
      @(negedge clk);
      #1;
      check_val("rst_wait", 32'(bus.m_waitrequest), 32'h3);
      check_val("rst_rdv", 32'(bus.m_readdatavalid), 32'h0);
      check_val("rst_cs", 32'(bus.ram_chipselect), 32'h0);
      check_val("rst_we", 32'(bus.ram_write), 32'h0);
      check_val("rst_clken", 32'(bus.ram_clken), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("clken_run", 32'(bus.ram_clken), 32'h1);
      @(negedge clk);

      // Write then read back
      do_write(0, 17'h00010, 32'hDEADBEEF, 4'hF);
      do_read(0, 17'h00010, 32'hDEADBEEF);

      // Byte-lane write
      do_write(0, 17'h00020, 32'h11223344, 4'hF);
      do_write(0, 17'h00020, 32'h0000AB00, 4'b0010);
      do_read(0, 17'h00020, 32'h1122AB44);

      // Read and write together: write wins, no read data strobe
      set_fields(0, 17'h00030, 32'h55AA55AA, 4'hF);
      bus.m_read[0] = 1'b1;
      bus.m_write[0] = 1'b1;
      wait_grant(0, "rw_grant");
      check_val("rw_we", 32'(bus.ram_write), 32'd1);
      @(negedge clk);
      bus.m_read[0] = 1'b0;
      bus.m_write[0] = 1'b0;
      #1;
      check_val("rw_no_rdv", 32'(bus.m_readdatavalid), 32'd0);
      @(negedge clk);
      do_read(0, 17'h00030, 32'h55AA55AA);

      // Both requesters stream reads: runs of MAX_HOLD, one IDLE cycle between
      @(negedge clk);
      @(negedge clk);
      set_fields(0, 17'h00001, 32'd0, 4'hF);
      set_fields(1, 17'h00002, 32'd0, 4'hF);
      bus.m_read = 2'b11;
      for (int k = 0; k < 15; k++) begin
         #1;
         exp_rdv = (k > 0 && exp_wr[k-1] != 2'b11) ? ~exp_wr[k-1] : 2'b00;
         check_val($sformatf("stream_wait%0d", k), 32'(bus.m_waitrequest), 32'(exp_wr[k]));
         check_val($sformatf("stream_rdv%0d", k), 32'(bus.m_readdatavalid), 32'(exp_rdv));
         @(negedge clk);
      end
      bus.m_read = 2'b00;
      @(negedge clk);
      @(negedge clk);

      // Reset right after an accepted read
      set_fields(0, 17'h00010, 32'd0, 4'hF);
      bus.m_read[0] = 1'b1;
      wait_grant(0, "rst_grant");
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.m_read[0] = 1'b0;
      #1;
      check_val("rstrd_rdv", 32'(bus.m_readdatavalid), 32'd0);
      check_val("rstrd_wait", 32'(bus.m_waitrequest), 32'h3);
      check_val("rstrd_cs", 32'(bus.ram_chipselect), 32'd0);
      @(negedge clk);
      #1;
      check_val("rstrd_rdv2", 32'(bus.m_readdatavalid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      check_val("postrst_rdv", 32'(bus.m_readdatavalid), 32'd0);
      check_val("postrst_wait", 32'(bus.m_waitrequest), 32'h3);

`ifdef TESTBENCH_LS_RAM_ARB_STATS_EN
      // Ten accepted reads from requester 1 after a clean reset
      @(negedge clk);
      set_fields(1, 17'h00005, 32'd0, 4'hF);
      bus.m_read[1] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!bus.m_waitrequest[1]) cnt++;
         if (cnt == 10) break;
         @(negedge clk);
      end
      check_val("stat_xfers", 32'(cnt), 32'd10);
      @(negedge clk);
      bus.m_read[1] = 1'b0;
      #1;
      check_val("stat_grants1", 32'(stat_grants[31:16]), 32'd10);
      check_val("stat_grants0", 32'(stat_grants[15:0]), 32'd0);
      check_val("stat_stalls1", 32'(stat_stalls[31:16]), 32'd1);
`else
      cnt = 0;
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/testbench_ls_ram_arbiter.md
TESTBENCH_LS_RAM_ARBITER -- requirements
Module: testbench_ls_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of Avalon-MM requesters (2..4).
REQ-002 SHALL have parameter MAX_HOLD, default 4, max consecutive accepted transfers per grant (1..15).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port m_address  input  NUM_REQ*17  per-requester word address.
REQ-006 SHALL have port m_byteenable  input  NUM_REQ*4  per-requester byte enables.
REQ-007 SHALL have port m_read  input  NUM_REQ  per-requester read request.
REQ-008 SHALL have port m_write  input  NUM_REQ  per-requester write request.
REQ-009 SHALL have port m_writedata  input  NUM_REQ*32  per-requester write data.
REQ-010 SHALL have port m_waitrequest  output  NUM_REQ  per-requester stall.
REQ-011 SHALL have port m_readdata  output  32  read data, shared by all requesters.
REQ-012 SHALL have port m_readdatavalid  output  NUM_REQ  per-requester read-data strobe.
REQ-013 SHALL have ports ram_address (17), ram_byteenable (4), ram_writedata (32), ram_chipselect (1), ram_write (1), ram_clken (1): outputs to the system RAM; ram_readdata (32): input from it.

Function
REQ-014 SHALL implement FSM states IDLE and OWNED, with registered owner index, rr_ptr and hold_cnt (4 bits).
REQ-015 In IDLE, all m_waitrequest SHALL be 1; if any requester asserts read or write, owner SHALL be set to the first requester at or after rr_ptr (modulo NUM_REQ), hold_cnt cleared, next state OWNED.
REQ-016 In OWNED, m_waitrequest[owner] SHALL be 0 and all others 1; any cycle the owner asserts read or write is one accepted transfer.
REQ-017 On an accepted transfer, ram_chipselect SHALL be 1 and ram_address/byteenable/writedata SHALL be the owner's fields, combinationally in the same cycle; ram_write SHALL equal the owner's m_write.
REQ-018 If an owner asserts read and write together, the write SHALL win and no readdatavalid SHALL be issued.
REQ-019 Read latency SHALL be exactly 1 cycle: m_readdatavalid[owner-of-read] SHALL pulse the cycle after the accepted read; m_readdata SHALL pass ram_readdata through.
REQ-020 hold_cnt SHALL increment per accepted transfer; OWNED SHALL exit to IDLE, rr_ptr <= owner+1 mod NUM_REQ, when the owner issues no request, or when an accepted transfer brings hold_cnt to MAX_HOLD while another requester is requesting.
REQ-021 With no competing request, the owner SHALL keep the grant beyond MAX_HOLD (hold_cnt saturates).
REQ-022 ram_chipselect and ram_write SHALL be 0 whenever no transfer is accepted; ram_clken SHALL be 1 whenever reset is low.
REQ-023 Back-to-back accepted transfers SHALL sustain one per cycle.

Reset
REQ-024 On reset: state IDLE, owner 0, rr_ptr 0, hold_cnt 0, read-valid pipeline cleared; m_waitrequest all 1, m_readdatavalid 0, ram_chipselect 0, ram_write 0, ram_clken 0.
REQ-025 A read accepted the cycle before reset asserts SHALL NOT produce readdatavalid after reset.

Configuration
REQ-026 With TESTBENCH_LS_RAM_ARB_STATS_EN defined, SHALL add output stat_grants (NUM_REQ*16) counting accepted transfers and stat_stalls (NUM_REQ*16) counting cycles with request asserted and waitrequest 1, both saturating at 16'hFFFF, cleared by reset; without it, those ports and counters SHALL not exist.

Structure
REQ-027 SHALL place RAM address width (17), data width (32), byte-enable width (4) and the FSM state enum in package testbench_ls_ram_pkg.
REQ-028 SHALL use one sub-module testbench_ls_rr_pick computing the round-robin winner from request vector and rr_ptr.

Verification
REQ-029 Requester 0 writes 32'hDEADBEEF to 17'h00010 with byteenable 4'hF, then reads it -> readdatavalid[0] one cycle after read acceptance, m_readdata 32'hDEADBEEF.
REQ-030 Both requesters stream reads continuously, MAX_HOLD=4 -> grants alternate in runs of 4 transfers plus one IDLE cycle; readdatavalid never asserted for the non-owner.
REQ-031 Byteenable 4'b0010 write of 32'h0000AB00 over 32'h11223344 -> readback 32'h1122AB44.
REQ-032 Owner asserts read and write together -> RAM write performed, no readdatavalid.
REQ-033 Reset asserted the cycle after an accepted read -> readdatavalid stays 0, waitrequest all 1 during reset.
REQ-034 With TESTBENCH_LS_RAM_ARB_STATS_EN, 10 accepted transfers from requester 1 -> stat_grants[1] = 10.
